// File: rtl/dma_ctrl_pkg.sv
// Shared definitions for the rotate-engine DMA tile sequencer.
package dma_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_PROC    = 3'd3,
    S_WR_REQ  = 3'd4,
    S_WR_WAIT = 3'd5,
    S_NEXT    = 3'd6,
    S_FIN     = 3'd7
  } state_t;

  localparam logic [2:0] XFER_SIZE_WORD = 3'b010;
  localparam int         WORD_BYTES     = 4;
  localparam int         MAX_BURST      = 16;

endpackage

// File: rtl/dma_ctrl_agen.sv
// Per-tile address generator: source/destination pointers and tile counter.
module dma_ctrl_agen #(
  parameter logic [31:0] SRC_STEP = 32'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] src_base,
  input  logic [31:0] dst_base,
  input  logic [31:0] dst_stride,
  output logic [31:0] src_ptr,
  output logic [31:0] dst_ptr,
  output logic [15:0] tile_cnt
);

  logic [31:0] stride_q;

  // Load on GO, advance once per fully written tile; sums wrap modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_ptr  <= '0;
      dst_ptr  <= '0;
      stride_q <= '0;
      tile_cnt <= '0;
    end else if (load) begin
      src_ptr  <= src_base;
      dst_ptr  <= dst_base;
      stride_q <= dst_stride;
      tile_cnt <= '0;
    end else if (step) begin
      src_ptr  <= src_ptr + SRC_STEP;
      dst_ptr  <= dst_ptr + stride_q;
      tile_cnt <= tile_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/dma_ctrl.sv
// Tile sequencer: read burst, rotate-core phase, write burst, per tile.
module dma_ctrl
  import dma_ctrl_pkg::*;
#(
  parameter int         BURST_WORDS = 16,
  parameter logic [2:0] XFER_SIZE   = XFER_SIZE_WORD
) (
  input  logic        I_DMAC_HCLK,
  input  logic        I_DMAC_HRESET,
  input  logic        I_DMAC_GO,
  input  logic        I_DMAC_ABORT,
  input  logic [31:0] I_DMAC_SRC_BASE,
  input  logic [31:0] I_DMAC_DST_BASE,
  input  logic [31:0] I_DMAC_DST_STRIDE,
  input  logic [15:0] I_DMAC_NUM_TILES,
  input  logic        I_DMAC_READY,
  input  logic        I_DMAC_PROC_DONE,
  output logic        O_DMAC_START,
  output logic [31:0] O_DMAC_ADDR,
  output logic [4:0]  O_DMAC_COUNT,
  output logic [2:0]  O_DMAC_SIZE,
  output logic        O_DMAC_WRITE,
  output logic        O_DMAC_BUSY,
  output logic        O_DMAC_PROC_START,
  output logic        O_DMAC_DONE,
  output logic [15:0] O_DMAC_TILE_CNT
);

  localparam logic [4:0]  COUNT_VAL = 5'(BURST_WORDS);
  localparam logic [31:0] SRC_STEP  = 32'(BURST_WORDS * WORD_BYTES);

  state_t      state;
  logic        abort_q;
  logic [15:0] num_tiles_q;
  logic [31:0] src_ptr;
  logic [31:0] dst_ptr;
  logic        go_ok;
  logic        abort_pend;
  logic        ag_load;
  logic        ag_step;

  // An abort arriving on the same cycle as a safe point is honoured there.
  assign go_ok      = (state == S_IDLE) && I_DMAC_GO && !I_DMAC_ABORT;
  assign abort_pend = abort_q || I_DMAC_ABORT;
  assign ag_load    = go_ok;
  // The tile counts as written once its write burst completes, even if aborting.
  assign ag_step    = (state == S_WR_WAIT) && I_DMAC_READY;

  dma_ctrl_agen #(
    .SRC_STEP (SRC_STEP)
  ) u_agen (
    .clk        (I_DMAC_HCLK),
    .rst        (I_DMAC_HRESET),
    .load       (ag_load),
    .step       (ag_step),
    .src_base   (I_DMAC_SRC_BASE),
    .dst_base   (I_DMAC_DST_BASE),
    .dst_stride (I_DMAC_DST_STRIDE),
    .src_ptr    (src_ptr),
    .dst_ptr    (dst_ptr),
    .tile_cnt   (O_DMAC_TILE_CNT)
  );

  // Sequencer FSM; outputs are set on the edge that enters the state they belong to.
  always_ff @(posedge I_DMAC_HCLK) begin
    if (I_DMAC_HRESET) begin
      state             <= S_IDLE;
      abort_q           <= 1'b0;
      num_tiles_q       <= '0;
      O_DMAC_START      <= 1'b0;
      O_DMAC_ADDR       <= '0;
      O_DMAC_COUNT      <= '0;
      O_DMAC_SIZE       <= '0;
      O_DMAC_WRITE      <= 1'b0;
      O_DMAC_BUSY       <= 1'b0;
      O_DMAC_PROC_START <= 1'b0;
      O_DMAC_DONE       <= 1'b0;
    end else begin
      O_DMAC_START      <= 1'b0;
      O_DMAC_PROC_START <= 1'b0;
      O_DMAC_DONE       <= 1'b0;
      O_DMAC_COUNT      <= COUNT_VAL;
      O_DMAC_SIZE       <= XFER_SIZE;
      if (state != S_IDLE && I_DMAC_ABORT) abort_q <= 1'b1;

      case (state)
        S_IDLE: begin
          if (go_ok) begin
            num_tiles_q <= I_DMAC_NUM_TILES;
            O_DMAC_BUSY <= 1'b1;
            if (I_DMAC_NUM_TILES == 16'd0) begin
              state       <= S_FIN;
              O_DMAC_DONE <= 1'b1;
            end else begin
              state        <= S_RD_REQ;
              O_DMAC_START <= 1'b1;
              O_DMAC_WRITE <= 1'b0;
              O_DMAC_ADDR  <= I_DMAC_SRC_BASE;
            end
          end
        end
        S_RD_REQ: state <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (I_DMAC_READY) begin
            if (abort_pend) begin
              state       <= S_IDLE;
              O_DMAC_BUSY <= 1'b0;
              abort_q     <= 1'b0;
            end else begin
              state             <= S_PROC;
              O_DMAC_PROC_START <= 1'b1;
            end
          end
        end
        S_PROC: begin
          if (I_DMAC_PROC_DONE) begin
            if (abort_pend) begin
              state       <= S_IDLE;
              O_DMAC_BUSY <= 1'b0;
              abort_q     <= 1'b0;
            end else begin
              state        <= S_WR_REQ;
              O_DMAC_START <= 1'b1;
              O_DMAC_WRITE <= 1'b1;
              O_DMAC_ADDR  <= dst_ptr;
            end
          end
        end
        S_WR_REQ: state <= S_WR_WAIT;
        S_WR_WAIT: begin
          if (I_DMAC_READY) begin
            if (abort_pend) begin
              state       <= S_IDLE;
              O_DMAC_BUSY <= 1'b0;
              abort_q     <= 1'b0;
            end else begin
              state <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          // Pointers and count were advanced on entry, so they are current here.
          if (abort_pend) begin
            state       <= S_IDLE;
            O_DMAC_BUSY <= 1'b0;
            abort_q     <= 1'b0;
          end else if (O_DMAC_TILE_CNT == num_tiles_q) begin
            state       <= S_FIN;
            O_DMAC_DONE <= 1'b1;
          end else begin
            state        <= S_RD_REQ;
            O_DMAC_START <= 1'b1;
            O_DMAC_WRITE <= 1'b0;
            O_DMAC_ADDR  <= src_ptr;
          end
        end
        S_FIN: begin
          state       <= S_IDLE;
          O_DMAC_BUSY <= 1'b0;
          abort_q     <= 1'b0;
        end
        default: begin
          state       <= S_IDLE;
          O_DMAC_BUSY <= 1'b0;
          abort_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule
